// File: rtl/sm_datapath.sv
`default_nettype none
// ============================================================================
// Module   : sm_datapath
// Purpose  : Shift-and-add multiplier datapath driven by the SMControl FSM
//            strobes; publishes a held product with a one-cycle valid pulse.
// Revision : 1.0
// ============================================================================
module sm_datapath #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   mcand_in,
    input  logic [W-1:0]   mplier_in,
    input  logic           mdld,
    input  logic           mrld,
    input  logic           rsload,
    input  logic           rsclear,
    input  logic           rsshr,
    output logic [W-1:0]   mr,
    output logic [2*W-1:0] product,
    output logic           product_valid,
    output logic           busy,
    output logic           proto_err
);

    localparam int            CW      = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(W);

    logic [W-1:0]   md_q,   md_d;
    logic [W-1:0]   mr_q,   mr_d;
    logic [2*W:0]   rs_q,   rs_d;
    logic [CW-1:0]  cnt_q,  cnt_d;
    logic           done_q, done_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic           pv_q,   pv_d;
    logic           busy_q, busy_d;
    logic           err_q,  err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_q   <= '0;
            mr_q   <= '0;
            rs_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            prod_q <= '0;
            pv_q   <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            md_q   <= md_d;
            mr_q   <= mr_d;
            rs_q   <= rs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            prod_q <= prod_d;
            pv_q   <= pv_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        md_d   = mdld ? mcand_in  : md_q;
        mr_d   = mrld ? mplier_in : mr_q;
        rs_d   = rs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        prod_d = prod_q;
        pv_d   = 1'b0;
        busy_d = busy_q;
        err_d  = err_q;

        // Capture happens before the rs operation so a same-cycle rsclear
        // still publishes the finished product and then restarts busy.
        if (done_q) begin
            prod_d = rs_q[2*W-1:0];
            pv_d   = 1'b1;
            busy_d = 1'b0;
        end

        if (rsclear) begin
            rs_d   = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            err_d  = 1'b0;
        end else begin
            if (rsload) begin
                rs_d[2*W:W] = {1'b0, rs_q[2*W-1:W]} + {1'b0, md_q};
            end else if (rsshr) begin
                rs_d = {1'b0, rs_q[2*W:1]};
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                done_d = (cnt_q == CNT_MAX - CW'(1));
            end
            if ((rsload && rsshr) ||
                (rsshr && (cnt_q == CNT_MAX)) ||
                ((rsload || rsshr) && !busy_q)) begin
                err_d = 1'b1;
            end
        end
    end

    assign mr            = mr_q;
    assign product       = prod_q;
    assign product_valid = pv_q;
    assign busy          = busy_q;
    assign proto_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_datapath
// Purpose  : Directed plus random multiply runs against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_sm_datapath;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   mcand_in, mplier_in;
    logic           mdld, mrld, rsload, rsclear, rsshr;
    logic [W-1:0]   mr;
    logic [2*W-1:0] product;
    logic           product_valid, busy, proto_err;

    int checks   = 0;
    int failures = 0;

    sm_datapath #(.W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .mcand_in      (mcand_in),
        .mplier_in     (mplier_in),
        .mdld          (mdld),
        .mrld          (mrld),
        .rsload        (rsload),
        .rsclear       (rsclear),
        .rsshr         (rsshr),
        .mr            (mr),
        .product       (product),
        .product_valid (product_valid),
        .busy          (busy),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One FSM-style multiply: START (clear + loads), per bit an add slot and a
    // shift slot, an idle END slot, then the product is expected.
    // errbit >= 0 drives rsload and rsshr together in that bit's add slot.
    task automatic run_mult(input int a, input int b, input int errbit);
        logic [W-1:0] bv;
        int           exp_p;
        logic         exp_err;
        logic [2*W-1:0] prev;
        bv      = W'(b);
        exp_p   = (errbit >= 0) ? a * (b | (1 << errbit)) : a * b;
        exp_err = 1'b0;
        mcand_in = W'(a); mplier_in = bv;
        mdld = 1'b1; mrld = 1'b1; rsclear = 1'b1;
        cyc();
        mdld = 1'b0; mrld = 1'b0; rsclear = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_mr", mr, b);
        chk("start_err", proto_err, 0);
        prev = product;
        for (int i = 0; i < W; i++) begin
            rsload = bv[i] | (i == errbit);
            rsshr  = (i == errbit);
            cyc();
            rsload = 1'b0; rsshr = 1'b0;
            if (i == errbit) exp_err = 1'b1;
            chk("add_err", proto_err, exp_err);
            chk("add_pv", product_valid, 0);
            rsshr = 1'b1;
            cyc();
            rsshr = 1'b0;
            chk("shift_busy", busy, 1);
            chk("shift_pv", product_valid, 0);
            chk("shift_prod_held", product, prev);
        end
        cyc();
        chk("done_product", product, exp_p);
        chk("done_pv", product_valid, 1);
        chk("done_busy", busy, 0);
        chk("done_err", proto_err, exp_err);
        cyc();
        chk("after_pv", product_valid, 0);
        chk("after_product", product, exp_p);
    endtask

    initial begin
        rst = 1'b0;
        mcand_in = '0; mplier_in = '0;
        mdld = 1'b0; mrld = 1'b0; rsload = 1'b0; rsclear = 1'b0; rsshr = 1'b0;
        cyc(); cyc();
        chk("rst_mr", mr, 0);
        chk("rst_product", product, 0);
        chk("rst_pv", product_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", proto_err, 0);
        rst = 1'b1;
        cyc();

        run_mult(13, 11, -1);
        run_mult(0, 15, -1);
        run_mult(9, 0, -1);
        run_mult(15, 15, -1);
        run_mult(15, 15, -1);

        // Asynchronous reset part-way through 7 x 6 (after the 2nd shift).
        mcand_in = 4'd7; mplier_in = 4'd6;
        mdld = 1'b1; mrld = 1'b1; rsclear = 1'b1;
        cyc();
        mdld = 1'b0; mrld = 1'b0; rsclear = 1'b0;
        rsshr = 1'b1; cyc(); rsshr = 1'b0;
        rsload = 1'b1; cyc(); rsload = 1'b0;
        rsshr = 1'b1; cyc(); rsshr = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_mr", mr, 0);
        chk("arst_product", product, 0);
        chk("arst_pv", product_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", proto_err, 0);
        cyc(); cyc();
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("arst_no_pv", product_valid, 0);
        end
        run_mult(7, 6, -1);

        // Simultaneous rsload/rsshr mid-run; a later rsclear must clear the flag.
        run_mult(10, 5, 1);
        run_mult(3, 3, -1);

        // Over-shift after completion.
        rsshr = 1'b1; cyc(); rsshr = 1'b0;
        chk("overshift_err", proto_err, 1);
        chk("overshift_pv", product_valid, 0);
        chk("overshift_product", product, 9);
        cyc(); cyc();
        chk("overshift_pv2", product_valid, 0);
        chk("overshift_product2", product, 9);

        run_mult(2, 3, -1);
        // rsload while idle.
        rsload = 1'b1; cyc(); rsload = 1'b0;
        chk("idle_load_err", proto_err, 1);
        chk("idle_load_pv", product_valid, 0);
        chk("idle_load_product", product, 6);
        cyc(); cyc();
        chk("idle_load_pv2", product_valid, 0);

        for (int r = 0; r < 8; r++) begin
            run_mult(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
